// File: rtl/sine_wave_pkg.sv
// rtl/sine_wave_pkg.sv - shared constants, quadrant code and quarter-wave table builder
package sine_wave_pkg;

  localparam int SW_DATA_WIDTH = 16;
  localparam int SW_LUT_DEPTH  = 8;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  function automatic int n_points(input int lut_depth);
    return 1 << lut_depth;
  endfunction

  function automatic int midscale(input int data_width);
    return 1 << (data_width - 1);
  endfunction

  function automatic int amplitude(input int data_width);
    return midscale(data_width) - 1;
  endfunction

  // Endpoints are exact; interior points never land on a rounding tie for power-of-two N.
  function automatic int quarter_sample(input int k, input int data_width, input int lut_depth);
    real x;
    real term;
    real acc;
    real scaled;
    int  quarter;
    quarter = n_points(lut_depth) / 4;
    if (k <= 0) return 0;
    if (k >= quarter) return amplitude(data_width);
    x    = 2.0 * 3.14159265358979323846 * real'(k) / real'(n_points(lut_depth));
    term = x;
    acc  = x;
    for (int i = 1; i <= 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      acc  = acc + term;
    end
    scaled = real'(amplitude(data_width)) * acc + 0.5;
    return $rtoi(scaled);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// rtl/sine_quarter_rom.sv - combinational quarter-wave magnitude table, N/4+1 entries
import sine_wave_pkg::*;

module sine_quarter_rom #(
  parameter int DATA_WIDTH = SW_DATA_WIDTH,
  parameter int LUT_DEPTH  = SW_LUT_DEPTH
) (
  input  logic [LUT_DEPTH-2:0]  index,
  output logic [DATA_WIDTH-2:0] magnitude
);

  localparam int ENTRIES = n_points(LUT_DEPTH) / 4 + 1;
  localparam logic [LUT_DEPTH-2:0] LAST_INDEX = {1'b1, {(LUT_DEPTH-2){1'b0}}};

  logic [DATA_WIDTH-2:0] rom [ENTRIES];

  for (genvar k = 0; k < ENTRIES; k++) begin : g_entry
    localparam logic [DATA_WIDTH-2:0] ENTRY_VALUE =
      (DATA_WIDTH-1)'(quarter_sample(k, DATA_WIDTH, LUT_DEPTH));
    assign rom[k] = ENTRY_VALUE;
  end

  always_comb begin
    magnitude = '0;
    if (index <= LAST_INDEX) magnitude = rom[index];
  end

endmodule

// File: rtl/sine_wave_table.sv
// rtl/sine_wave_table.sv - full-period sine sample from a quarter table, registered offset-binary output
import sine_wave_pkg::*;

module sine_wave_table #(
  parameter int DATA_WIDTH = SW_DATA_WIDTH,
  parameter int LUT_DEPTH  = SW_LUT_DEPTH
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [LUT_DEPTH-1:0]  address,
  output logic [DATA_WIDTH-1:0] value
);

  localparam logic [LUT_DEPTH-2:0]  QUARTER = {1'b1, {(LUT_DEPTH-2){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MID     = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  quadrant_t             quad;
  logic [LUT_DEPTH-3:0]  low;
  logic [LUT_DEPTH-2:0]  rom_index;
  logic [DATA_WIDTH-2:0] magnitude;
  logic [DATA_WIDTH-1:0] sample;

  assign quad = quadrant_t'(address[LUT_DEPTH-1:LUT_DEPTH-2]);
  assign low  = address[LUT_DEPTH-3:0];

  // Falling quadrants read the table backwards; index N/4 is the peak entry.
  always_comb begin
    rom_index = {1'b0, low};
    if (quad == Q1 || quad == Q3) rom_index = QUARTER - {1'b0, low};
  end

  sine_quarter_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .LUT_DEPTH  (LUT_DEPTH)
  ) u_rom (
    .index     (rom_index),
    .magnitude (magnitude)
  );

  // |s| <= M-1, so the sum stays within 1..2M-1 without saturation.
  always_comb begin
    sample = MID + {1'b0, magnitude};
    if (quad == Q2 || quad == Q3) sample = MID - {1'b0, magnitude};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) value <= MID;
    else         value <= sample;
  end

endmodule

// File: tb/tb_sine_wave_table.sv
// tb/tb_sine_wave_table.sv - self-checking bench for sine_wave_table at 16/8 and 8/4
module tb_sine_wave_table;

  logic        clk;
  logic        arst_n;
  logic [7:0]  address;
  logic [15:0] value;
  logic [3:0]  a8;
  logic [7:0]  value8;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  int exp16 = 0;
  int exp8  = 0;
  int vals [256];
  int vals8 [16];
  int seq [$];

  sine_wave_table #(.DATA_WIDTH(16), .LUT_DEPTH(8)) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .address (address),
    .value   (value)
  );

  sine_wave_table #(.DATA_WIDTH(8), .LUT_DEPTH(4)) dut8 (
    .clk     (clk),
    .arst_n  (arst_n),
    .address (a8),
    .value   (value8)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int golden(input int a, input int dw, input int ld);
    real amp;
    real v;
    int  s;
    amp = real'((1 << (dw - 1)) - 1);
    v   = amp * $sin(2.0 * 3.14159265358979323846 * real'(a) / real'(1 << ld));
    if (v >= 0.0) s = int'($floor(v + 0.5));
    else          s = -int'($floor(-v + 0.5));
    return (1 << (dw - 1)) + s;
  endfunction

  // Reference: the sample for the address seen at the last edge, or midscale while in reset.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      exp16 = 32768;
      exp8  = 128;
    end else begin
      exp16 = golden(int'(address), 16, 8);
      exp8  = golden(int'(a8), 8, 4);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (int'(value) !== exp16) begin
        fails++;
        $display("FAIL model16 at %0t: got %0d, expected %0d", $time, value, exp16);
      end
      tests++;
      if (int'(value8) !== exp8) begin
        fails++;
        $display("FAIL model8 at %0t: got %0d, expected %0d", $time, value8, exp8);
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic step(input int a);
    address = 8'(a);
    @(negedge clk);
  endtask

  task automatic step8(input int a);
    a8 = 4'(a);
    @(negedge clk);
  endtask

  initial begin
    int card_addr [4];
    int card_val  [4];
    int card8_val [4];
    card_addr = '{0, 64, 128, 192};
    card_val  = '{32768, 65535, 32768, 1};
    card8_val = '{128, 255, 128, 1};

    arst_n  = 1;
    address = 0;
    a8      = 0;
    #1 arst_n = 0;
    #1;
    check("reset_immediate", int'(value), 32768);
    check("reset_immediate8", int'(value8), 128);

    @(negedge clk);
    arst_n  = 1;
    address = 64;
    @(negedge clk);
    check("reset_release", int'(value), 65535);
    chk_en = 1;

    for (int i = 0; i < 4; i++) begin
      step(card_addr[i]);
      check($sformatf("cardinal_%0d", card_addr[i]), int'(value), card_val[i]);
    end
    step(32);
    check("addr_32", int'(value), 55938);
    step(255);
    check("addr_255", int'(value), 31964);

    for (int a = 0; a < 256; a++) begin
      step(a);
      vals[a] = int'(value);
    end
    for (int a = 0; a < 128; a++)
      check($sformatf("symmetry_%0d", a), vals[a] + vals[a + 128], 65536);

    for (int a = 190; a < 256; a++) begin
      step(a);
      if (a >= 192) seq.push_back(int'(value));
      if (a == 255) check("wrap_255_below_mid", int'(value < 16'd32768), 1);
    end
    for (int a = 0; a <= 66; a++) begin
      step(a);
      if (a <= 64) seq.push_back(int'(value));
      if (a == 0) check("wrap_0_mid", int'(value), 32768);
    end
    check("monotonic_len", seq.size(), 129);
    for (int i = 1; i < seq.size(); i++)
      check($sformatf("monotonic_%0d", i), int'(seq[i] >= seq[i - 1]), 1);

    step(100);
    #2 arst_n = 0;
    #1;
    check("mid_reset_immediate", int'(value), 32768);
    @(negedge clk);
    check("mid_reset_held", int'(value), 32768);
    address = 101;
    arst_n  = 1;
    @(negedge clk);
    check("post_reset_101", int'(value), golden(101, 16, 8));

    for (int i = 0; i < 4; i++) begin
      step8(card_addr[i] / 16);
      check($sformatf("cardinal8_%0d", card_addr[i] / 16), int'(value8), card8_val[i]);
    end
    for (int a = 0; a < 16; a++) begin
      step8(a);
      vals8[a] = int'(value8);
    end
    for (int a = 0; a < 16; a++)
      check($sformatf("symmetry8_%0d", a), vals8[a] + vals8[(a + 8) % 16], 256);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
